// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// disp_pkg : shared FSM encoding and AXI constants for the display VRAM reader
// Revision : 1.0
// ============================================================================
package disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FRST    = 3'd1,
    ST_CHKBUF  = 3'd2,
    ST_SETADDR = 3'd3,
    ST_READ    = 3'd4,
    ST_WAITFRM = 3'd5
  } state_e;

  localparam logic [2:0] ARSIZE      = 3'b011;  // 8-byte beats
  localparam logic [1:0] ARBURST     = 2'b01;   // INCR
  localparam int         BURST_BYTES = 128;
  localparam int         BURST_SHIFT = 7;
  localparam int         BCNT_W      = 14;

endpackage
`default_nettype wire

// File: rtl/disp_vramctrl.sv
`default_nettype none
// ============================================================================
// disp_vramctrl : AXI4 read master refilling the display FIFO from VRAM
// Revision      : 1.0
// ============================================================================
module disp_vramctrl
  import disp_pkg::*;
#(
  parameter int H_PIX       = 640,
  parameter int V_PIX       = 480,
  parameter int BURST_LEN   = 16,
  parameter int FIFORST_CYC = 8
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISPON,
  input  logic        VSTART,
  input  logic [31:0] DISPADDR,
  input  logic        BUF_WREADY,
  output logic        FIFORST,
  output logic [63:0] FIFOIN,
  output logic        FIFOWR,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        BUSY
);

  localparam int BEATS  = H_PIX * V_PIX / 2;
  localparam int BURSTS = BEATS / BURST_LEN;

  localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(BURSTS - 1);
  localparam logic [7:0]        FRST_LAST  = 8'(FIFORST_CYC - 1);

  state_e              state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [7:0]          frst_cnt_q, frst_cnt_d;
  logic                fiforst_q, fiforst_d;
  logic                arvalid_q, arvalid_d;
  logic [31:0]         araddr_q, araddr_d;
  logic                rready_q, rready_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    bcnt_d     = bcnt_q;
    frst_cnt_d = frst_cnt_q;
    fiforst_d  = fiforst_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    rready_d   = rready_q;

    case (state_q)
      ST_IDLE, ST_WAITFRM: begin
        if (DISPON && VSTART) begin
          // Frame base is aligned to a whole burst
          state_d    = ST_FRST;
          base_d     = DISPADDR & ~32'h0000_007F;
          bcnt_d     = '0;
          frst_cnt_d = '0;
          fiforst_d  = 1'b1;
        end else if (!DISPON) begin
          state_d = ST_IDLE;
        end
      end
      ST_FRST: begin
        frst_cnt_d = frst_cnt_q + 8'd1;
        if (frst_cnt_q == FRST_LAST) begin
          fiforst_d = 1'b0;
          state_d   = ST_CHKBUF;
        end
      end
      ST_CHKBUF: begin
        if (!DISPON) begin
          state_d = ST_IDLE;
        end else if (BUF_WREADY) begin
          state_d   = ST_SETADDR;
          arvalid_d = 1'b1;
          araddr_d  = base_q + 32'({bcnt_q, {BURST_SHIFT{1'b0}}});
        end
      end
      ST_SETADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        // A falling DISPON is handled in CHKBUF so the burst always drains
        if (RVALID && RLAST) begin
          rready_d = 1'b0;
          bcnt_d   = bcnt_q + 1'b1;
          state_d  = (bcnt_q == LAST_BURST) ? ST_WAITFRM : ST_CHKBUF;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_WAITFRM));
  end

  always_ff @(posedge ACLK) begin
    if (!ARST) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      bcnt_q     <= '0;
      frst_cnt_q <= '0;
      fiforst_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      bcnt_q     <= bcnt_d;
      frst_cnt_q <= frst_cnt_d;
      fiforst_q  <= fiforst_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      rready_q   <= rready_d;
      busy_q     <= busy_d;
    end
  end

  assign FIFORST = fiforst_q;
  assign FIFOIN  = RDATA;
  assign FIFOWR  = RVALID & rready_q;
  assign ARADDR  = araddr_q;
  assign ARLEN   = 8'(BURST_LEN - 1);
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign BUSY    = busy_q;

endmodule
`default_nettype wire
